sound_gen: RTL and testbench
============================

SOUND_GEN -- requirements
Module: sound_gen

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter NOTE_MS, default 150, meaning jingle note length in ms.
REQ-003 SHALL have port clk  input  1  single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port lamp  input  2  encoded lamp index 0..3 from the controller.
REQ-006 SHALL have port lamp_ena  input  1  lamp lit; lamp is valid only while high.
REQ-007 SHALL have port lose  input  1  controller lose flag (level).
REQ-008 SHALL have port hs  input  1  controller high-score flag (level).
REQ-009 SHALL have port spk  output  1  square-wave speaker drive.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-011 SHALL use half-period table HALF[i] = CLK_HZ/(2*F[i]), truncating integer division, with F = {415, 310, 252, 209} Hz.
REQ-012 SHALL use note length NOTE_CYC = CLK_HZ*NOTE_MS/1000 cycles.
REQ-013 SHALL size counter widths by $clog2 of their largest count, with no overflow at the default parameters.
REQ-014 SHALL implement states IDLE, LAMP, LOSE and HS.
REQ-015 SHALL detect rising edges of lose and hs against registered copies of each input.
REQ-016 SHALL start tones with priority lose edge > hs edge > lamp_ena, evaluated in IDLE and LAMP only.
REQ-017 SHALL ignore lose and hs edges while in LOSE or HS; a running jingle is never retriggered or preempted.
REQ-018 SHALL, in IDLE, hold spk=0; lamp_ena=1 moves the state to LAMP with tone index = lamp.
REQ-019 SHALL, on any tone start, load the divider with HALF[idx]-1 and drive spk=0.
REQ-020 SHALL count the divider down each cycle; at 0, spk toggles and the divider reloads, giving a period of exactly 2*HALF[idx] cycles.
REQ-021 SHALL, in LAMP, reload the divider and force spk=0 on the next edge when lamp changes while lamp_ena=1.
REQ-022 SHALL, in LAMP, return to IDLE with spk=0 on the edge after lamp_ena falls.
REQ-023 SHALL, in LOSE, play note indices 3,2,1,0 for NOTE_CYC cycles each, then enter IDLE with spk=0.
REQ-024 SHALL, in HS, play note indices 0,1,2,3 for NOTE_CYC cycles each, then enter IDLE with spk=0.
REQ-025 SHALL restart the divider at each note boundary per REQ-019.
REQ-026 SHALL, on the cycle a jingle ends, go directly to LAMP if lamp_ena=1, else to IDLE.
REQ-027 SHALL have a latency of 1 cycle from the qualifying input to state/busy change.

Reset
REQ-028 SHALL, while rst_n=0, force state IDLE, spk=0, busy=0, all counters 0 and edge registers 0.
REQ-029 SHALL, as a consequence of REQ-028, treat lose or hs already high at reset release as a rising edge.
REQ-030 SHALL, on reset assertion mid-tone or mid-jingle, silence spk immediately (asynchronously).

Configuration
REQ-031 SHALL support macro SOUND_JINGLE_EN.
REQ-032 SHALL, with SOUND_JINGLE_EN defined, behave as specified above.
REQ-033 SHALL, without SOUND_JINGLE_EN, omit the LOSE/HS states and note timer, ignore lose and hs, and play lamp tones only; the port list is unchanged.

Structure
REQ-034 SHALL place the state enum, the F table, the HALF function and the NOTE_CYC function in shared package sound_pkg.
REQ-035 SHALL implement the reloadable half-period divider as sub-module tone_div (inputs load, half; output toggle).

Verification (CLK_HZ=83000, NOTE_MS=150 -> HALF={100,133,164,198}, NOTE_CYC=12450)
REQ-036 SHALL check: lamp=0, lamp_ena=1 for 1000 cycles -> spk period 200 cycles, first rise 100 cycles after busy; lamp_ena=0 -> spk=0 and busy=0 on the next edge.
REQ-037 SHALL check: lamp changes 1->3 mid-tone -> spk=0 the next cycle, then period 396 cycles.
REQ-038 SHALL check: lose pulse -> busy for 4*12450 cycles with periods 396, 328, 266, 200; a second lose pulse or hs during the jingle has no effect.
REQ-039 SHALL check: hs and lose rise on the same cycle while in LAMP -> LOSE sequence plays; lamp_ena still 1 at the end -> LAMP resumes.
REQ-040 SHALL check: rst_n asserted mid-jingle -> spk=0 and busy=0 immediately; release with lose=1 -> LOSE restarts.
REQ-041 SHALL check: build without SOUND_JINGLE_EN -> lose and hs pulses leave busy=0 and spk=0.

Source files
------------

// File: rtl/sound_pkg.sv
// sound_pkg -- shared definitions for the sound_gen block.
//   state_e   : controller states (IDLE, LAMP, LOSE, HS)
//   F_HZ      : lamp tone frequencies in Hz, indexed by tone index 0..3
//   half_cyc  : half-period of tone idx in clock cycles (truncating)
//   note_cyc  : jingle note length in clock cycles
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LAMP = 2'd1,
    ST_LOSE = 2'd2,
    ST_HS   = 2'd3
  } state_e;

  localparam int unsigned F_HZ [4] = '{32'd415, 32'd310, 32'd252, 32'd209};

  function automatic int unsigned half_cyc(input int unsigned clk_hz, input logic [1:0] idx);
    return clk_hz / (32'd2 * F_HZ[idx]);
  endfunction

  // 64-bit product: CLK_HZ*NOTE_MS exceeds 32 bits at the default clock.
  function automatic int unsigned note_cyc(input int unsigned clk_hz, input int unsigned note_ms);
    longint unsigned prod;
    prod = 64'(clk_hz) * 64'(note_ms) / 64'd1000;
    return 32'(prod);
  endfunction

endpackage

// File: rtl/sound_gen_if.sv
// sound_gen_if -- controller-to-sound-generator signal bundle.
//   lamp     : encoded lamp index 0..3 (valid while lamp_ena)
//   lamp_ena : lamp lit
//   lose, hs : level flags from the controller
//   spk      : square-wave speaker drive
//   busy     : generator is not idle
// master = controller side, slave = sound_gen side.
interface sound_gen_if;
  logic [1:0] lamp;
  logic       lamp_ena;
  logic       lose;
  logic       hs;
  logic       spk;
  logic       busy;

  modport master (output lamp, lamp_ena, lose, hs, input spk, busy);
  modport slave  (input lamp, lamp_ena, lose, hs, output spk, busy);
endinterface

// File: rtl/sound_gen_tone_div.sv
// tone_div -- reloadable half-period down-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : restart the count from half
//   half       : reload value (half-period in cycles minus one)
//   toggle     : one-cycle strobe when the count expires; the speaker
//                flips on that edge and the counter reloads itself
module tone_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] half,
  output logic         toggle
);

  logic [W-1:0] cnt_r;

  // Down-counter that restarts from the reload value on load or on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load || (cnt_r == '0)) begin
      cnt_r <= half;
    end else begin
      cnt_r <= cnt_r - W'(1);
    end
  end

  assign toggle = !load && (cnt_r == '0);

endmodule

// File: rtl/sound_gen.sv
// sound_gen -- lamp tone and lose/high-score jingle generator.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (silences spk at once)
//   bus   : sound_gen_if.slave (lamp, lamp_ena, lose, hs in; spk, busy out)
// Parameters: CLK_HZ (clock in Hz), NOTE_MS (jingle note length in ms).
// Build option: define SOUND_JINGLE_EN to enable the LOSE/HS jingles;
// without it lose and hs are ignored and only lamp tones play.
module sound_gen #(
  parameter int unsigned CLK_HZ  = 32'd50_000_000,
  parameter int unsigned NOTE_MS = 32'd150
) (
  input logic        clk,
  input logic        rst_n,
  sound_gen_if.slave bus
);

  import sound_pkg::*;

  // Index 3 has the lowest frequency and therefore the longest half-period.
  localparam int HALF_W = $clog2(half_cyc(CLK_HZ, 2'd3));
  localparam logic [HALF_W-1:0] RELOAD [4] = '{
    HALF_W'(half_cyc(CLK_HZ, 2'd0) - 32'd1),
    HALF_W'(half_cyc(CLK_HZ, 2'd1) - 32'd1),
    HALF_W'(half_cyc(CLK_HZ, 2'd2) - 32'd1),
    HALF_W'(half_cyc(CLK_HZ, 2'd3) - 32'd1)
  };

  state_e            state_r, state_nxt_s;
  logic [1:0]        idx_r, idx_nxt_s;
  logic              spk_r, spk_nxt_s;
  logic              busy_r;
  logic              load_s, toggle_s;
  logic [HALF_W-1:0] half_s;

`ifdef SOUND_JINGLE_EN
  localparam int unsigned NOTE_CYC = note_cyc(CLK_HZ, NOTE_MS);
  localparam int NOTE_W = $clog2(NOTE_CYC);
  localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(NOTE_CYC - 32'd1);

  logic              lose_q_r, hs_q_r;
  logic              lose_rise_s, hs_rise_s;
  logic [NOTE_W-1:0] note_cnt_r, note_cnt_nxt_s;
  logic [1:0]        note_num_r, note_num_nxt_s;

  assign lose_rise_s = bus.lose & ~lose_q_r;
  assign hs_rise_s   = bus.hs & ~hs_q_r;
`else
  logic unused_s;
  assign unused_s = bus.lose ^ bus.hs;
`endif

  // The reload value follows the tone index that will be current after this edge.
  assign half_s = RELOAD[idx_nxt_s];

  tone_div #(.W(HALF_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load_s),
    .half   (half_s),
    .toggle (toggle_s)
  );

  // Next-state, tone selection, note sequencing and speaker decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_s      = 1'b0;
    spk_nxt_s   = spk_r;
`ifdef SOUND_JINGLE_EN
    note_cnt_nxt_s = note_cnt_r;
    note_num_nxt_s = note_num_r;
`endif
    case (state_r)
      ST_IDLE, ST_LAMP: begin
`ifdef SOUND_JINGLE_EN
        if (lose_rise_s) begin
          state_nxt_s    = ST_LOSE;
          idx_nxt_s      = 2'd3;
          load_s         = 1'b1;
          note_cnt_nxt_s = '0;
          note_num_nxt_s = 2'd0;
        end else if (hs_rise_s) begin
          state_nxt_s    = ST_HS;
          idx_nxt_s      = 2'd0;
          load_s         = 1'b1;
          note_cnt_nxt_s = '0;
          note_num_nxt_s = 2'd0;
        end else
`endif
        if (!bus.lamp_ena) begin
          state_nxt_s = ST_IDLE;
        end else if ((state_r == ST_IDLE) || (bus.lamp != idx_r)) begin
          state_nxt_s = ST_LAMP;
          idx_nxt_s   = bus.lamp;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = ST_LAMP;
        end
      end
`ifdef SOUND_JINGLE_EN
      ST_LOSE, ST_HS: begin
        if (note_cnt_r == NOTE_LAST) begin
          note_cnt_nxt_s = '0;
          load_s         = 1'b1;
          if (note_num_r == 2'd3) begin
            // Jingle over: fall straight into a lamp tone if one is lit.
            if (bus.lamp_ena) begin
              state_nxt_s = ST_LAMP;
              idx_nxt_s   = bus.lamp;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            note_num_nxt_s = note_num_r + 2'd1;
            idx_nxt_s      = (state_r == ST_LOSE) ? (idx_r - 2'd1) : (idx_r + 2'd1);
          end
        end else begin
          note_cnt_nxt_s = note_cnt_r + NOTE_W'(1);
        end
      end
`endif
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // Every tone start and every idle cycle begins with the speaker low.
    if (load_s || (state_nxt_s == ST_IDLE)) begin
      spk_nxt_s = 1'b0;
    end else if (toggle_s) begin
      spk_nxt_s = !spk_r;
    end else begin
      spk_nxt_s = spk_r;
    end
  end

  // State, tone index, speaker and busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      spk_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      spk_r   <= spk_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

`ifdef SOUND_JINGLE_EN
  // Edge-detect copies of lose/hs and jingle note timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lose_q_r   <= 1'b0;
      hs_q_r     <= 1'b0;
      note_cnt_r <= '0;
      note_num_r <= 2'd0;
    end else begin
      lose_q_r   <= bus.lose;
      hs_q_r     <= bus.hs;
      note_cnt_r <= note_cnt_nxt_s;
      note_num_r <= note_num_nxt_s;
    end
  end
`endif

  assign bus.spk  = spk_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_sound_gen.sv
// tb_sound_gen -- self-checking bench for sound_gen at CLK_HZ=83000,
// NOTE_MS=150. The reference model tracks the current tone/jingle and the
// cycles elapsed since it started, and derives spk arithmetically from
// the half-period table. Jingle scenarios run when SOUND_JINGLE_EN is set.
module tb_sound_gen;

  localparam int CLK_HZ  = 83000;
  localparam int NOTE_MS = 150;
  localparam int NOTE    = CLK_HZ * NOTE_MS / 1000;
`ifdef SOUND_JINGLE_EN
  localparam bit JEN = 1'b1;
`else
  localparam bit JEN = 1'b0;
`endif

  int freq [4] = '{415, 310, 252, 209};
  int half [4];

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sound_gen_if bus_if ();

  sound_gen #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 idle, 1 lamp tone, 2 lose jingle, 3 hs jingle.
  int m_mode = 0;
  int m_idx  = 0;
  int m_t    = 0;
  bit m_lose_q = 1'b0;
  bit m_hs_q   = 1'b0;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: busy,spk=%b expected %b", tag, $time, got, exp);
    end
  endtask

  function automatic logic [1:0] model_out();
    int n, id;
    if (m_mode == 0) return 2'b00;
    if (m_mode == 1) return {1'b1, 1'((m_t / half[m_idx]) % 2)};
    n  = m_t / NOTE;
    id = (m_mode == 2) ? (3 - n) : n;
    return {1'b1, 1'(((m_t % NOTE) / half[id]) % 2)};
  endfunction

  task automatic model_step(input int li, input bit le, input bit lo, input bit h);
    bit lr, hr;
    lr = lo && !m_lose_q;
    hr = h && !m_hs_q;
    m_lose_q = lo;
    m_hs_q   = h;
    if (m_mode <= 1) begin
      if (JEN && lr) begin
        m_mode = 2; m_t = 0;
      end else if (JEN && hr) begin
        m_mode = 3; m_t = 0;
      end else if (!le) begin
        m_mode = 0; m_t = 0;
      end else if (m_mode == 0 || li != m_idx) begin
        m_mode = 1; m_idx = li; m_t = 0;
      end else begin
        m_t++;
      end
    end else begin
      m_t++;
      if (m_t == 4 * NOTE) begin
        if (le) begin
          m_mode = 1; m_idx = li;
        end else begin
          m_mode = 0;
        end
        m_t = 0;
      end
    end
  endtask

  // Drive inputs just after a falling edge, advance the model over the
  // coming rising edge, and compare on the next falling edge.
  task automatic cycle(input string tag, input logic [1:0] li, input bit le, input bit lo, input bit h);
    bus_if.lamp     = li;
    bus_if.lamp_ena = le;
    bus_if.lose     = lo;
    bus_if.hs       = h;
    if (rst_n) model_step(int'(li), le, lo, h);
    @(negedge clk);
    check(tag, {bus_if.busy, bus_if.spk}, model_out());
  endtask

  // Assert reset mid-cycle; outputs must drop before any clock edge.
  task automatic apply_reset(input string tag, input int n);
    #2 rst_n = 1'b0;
    #1 check({tag, "_async"}, {bus_if.busy, bus_if.spk}, 2'b00);
    m_mode = 0; m_t = 0; m_lose_q = 1'b0; m_hs_q = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check(tag, {bus_if.busy, bus_if.spk}, 2'b00);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] li;
    bit le, lo, h;
    int len;

    for (int i = 0; i < 4; i++) half[i] = CLK_HZ / (2 * freq[i]);
    bus_if.lamp = 2'd0; bus_if.lamp_ena = 1'b0; bus_if.lose = 1'b0; bus_if.hs = 1'b0;

    #1 check("rst", {bus_if.busy, bus_if.spk}, 2'b00);
    repeat (3) begin
      @(negedge clk);
      check("rst", {bus_if.busy, bus_if.spk}, 2'b00);
    end
    rst_n = 1'b1;

    repeat (5) cycle("idle", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (1000) cycle("lamp0", 2'd0, 1'b1, 1'b0, 1'b0);
    cycle("lamp0_off", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) cycle("idle", 2'd0, 1'b0, 1'b0, 1'b0);
    repeat (250) cycle("lamp1", 2'd1, 1'b1, 1'b0, 1'b0);
    repeat (900) cycle("lamp3", 2'd3, 1'b1, 1'b0, 1'b0);
    apply_reset("rst_tone", 3);
    repeat (5) cycle("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Random lamp activity; lose/hs pulses only where jingles are disabled.
    for (int s = 0; s < 30; s++) begin
      li  = 2'($urandom_range(0, 3));
      le  = ($urandom_range(0, 3) != 0);
      lo  = !JEN && ($urandom_range(0, 1) == 1);
      h   = !JEN && ($urandom_range(0, 1) == 1);
      len = $urandom_range(1, 300);
      for (int c = 0; c < len; c++)
        cycle("rand", li, le, lo && (c < 3), h && (c >= 2) && (c < 5));
    end

`ifdef SOUND_JINGLE_EN
    // hs and lose rise together from LAMP; retriggers during the jingle
    // are ignored; lamp still lit at the end resumes the lamp tone.
    repeat (50) cycle("lamp2", 2'd2, 1'b1, 1'b0, 1'b0);
    cycle("both", 2'd2, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4 * NOTE + 600; c++) begin
      lo = (c < 3000) || ((c >= 5000) && (c < 5010));
      h  = (c < 100) || ((c >= 20000) && (c < 20005));
      le = (c < 10000) || (c >= 30000);
      cycle("lose_jng", 2'd2, le, lo, h);
    end
    repeat (5) cycle("idle2", 2'd0, 1'b0, 1'b0, 1'b0);

    // High-score jingle ascends; cut short by reset, then lose held high
    // across reset release starts the lose jingle again.
    for (int c = 0; c < 14000; c++) cycle("hs_jng", 2'd1, 1'b0, 1'b0, c < 10);
    bus_if.lose = 1'b1;
    apply_reset("rst_jng", 4);
    for (int c = 0; c < 3000; c++) cycle("lose_rst", 2'd0, 1'b0, 1'b1, 1'b0);
`else
    // Jingles disabled: lose/hs pulses must leave the block silent.
    for (int p = 0; p < 6; p++) begin
      cycle("flag_lose", 2'd2, 1'b0, 1'b1, 1'b0);
      repeat (20) cycle("flag_idle", 2'd2, 1'b0, 1'b0, 1'b0);
      cycle("flag_hs", 2'd2, 1'b0, 1'b0, 1'b1);
      repeat (20) cycle("flag_idle", 2'd2, 1'b0, 1'b0, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
